// File: rtl/vga_square_renderer.sv
// 640x480@60 VGA timing generator that draws a solid square at a frame-latched position.
// Optional VGA_BORDER_EN adds a white 1-pixel border around the active area.
module vga_square_renderer #(
    parameter int         H_ACTIVE = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACTIVE = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter int         SQ_SIZE  = 16,
    parameter logic [5:0] SQ_COLOR = 6'b110000,
    parameter logic [5:0] BG_COLOR = 6'b000001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sq_x,
    input  logic [9:0] sq_y,
    input  logic       sq_valid,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [5:0] rgb,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] SQ_EXT  = 11'(SQ_SIZE);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] lat_x;
    logic [9:0] lat_y;

    logic       active;
    logic       hit;
    logic       latch_point;
    logic       hsync_nxt;
    logic       vsync_nxt;
    logic [5:0] rgb_nxt;
    logic [10:0] x_end;
    logic [10:0] y_end;

    assign latch_point = (h_cnt == 10'd0) && (v_cnt == V_ACT);
    assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync_nxt   = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
    assign vsync_nxt   = !((v_cnt >= VS_START) && (v_cnt <= VS_END));

    // 11-bit end coordinates keep squares near the far edge clipped instead of wrapped.
    assign x_end = {1'b0, lat_x} + SQ_EXT;
    assign y_end = {1'b0, lat_y} + SQ_EXT;
    assign hit   = (h_cnt >= lat_x) && ({1'b0, h_cnt} < x_end) &&
                   (v_cnt >= lat_y) && ({1'b0, v_cnt} < y_end);

    always_comb begin
        rgb_nxt = 6'b000000;
        if (active) begin
            if (hit) begin
                rgb_nxt = SQ_COLOR;
            end else begin
                rgb_nxt = BG_COLOR;
            end
`ifdef VGA_BORDER_EN
            if ((h_cnt == 10'd0) || (h_cnt == H_ACT - 10'd1) ||
                (v_cnt == 10'd0) || (v_cnt == V_ACT - 10'd1)) begin
                rgb_nxt = 6'b111111;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Position is sampled only at the start of vertical blanking so a frame never tears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_x <= 10'd0;
            lat_y <= 10'd0;
        end else if (latch_point && sq_valid) begin
            lat_x <= sq_x;
            lat_y <= sq_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            de         <= 1'b0;
            rgb        <= 6'b000000;
            frame_tick <= 1'b0;
            hpos       <= 10'd0;
            vpos       <= 10'd0;
        end else begin
            hsync      <= hsync_nxt;
            vsync      <= vsync_nxt;
            de         <= active;
            rgb        <= rgb_nxt;
            frame_tick <= latch_point;
            hpos       <= h_cnt;
            vpos       <= v_cnt;
        end
    end

endmodule

// File: tb/tb_vga_square_renderer.sv
// Directed bench for vga_square_renderer using a scaled-down raster (80x46) to keep runs short.
// Border expectations follow VGA_BORDER_EN when it is defined for the build.
module tb_vga_square_renderer;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 40, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [5:0] SQ = 6'b110000;
    localparam logic [5:0] BG = 6'b000001;
    localparam logic [5:0] WH = 6'b111111;
`ifdef VGA_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sq_x = 10'd0;
    logic [9:0] sq_y = 10'd0;
    logic       sq_valid = 1'b0;
    logic       frame_tick, hsync, vsync, de;
    logic [5:0] rgb;
    logic [9:0] hpos, vpos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_square_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SQ_SIZE(16), .SQ_COLOR(SQ), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sq_x(sq_x), .sq_y(sq_y), .sq_valid(sq_valid),
        .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync), .de(de),
        .rgb(rgb), .hpos(hpos), .vpos(vpos)
    );

    function automatic logic [5:0] exp_col(int x, int y, logic [5:0] base);
        if (BORDER && (x == 0 || x == HA - 1 || y == 0 || y == VA - 1)) return WH;
        return base;
    endfunction

    task automatic wait_pix(int x, int y);
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (hpos == 10'(x) && vpos == 10'(y)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pix timeout target=(%0d,%0d) last=(%0d,%0d)", x, y, hpos, vpos);
    endtask

    task automatic wait_tick();
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_tick timeout");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks += 7;
        if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
        if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
        if (de !== 1'b0) begin errors++; $display("FAIL reset_de got=%b exp=0", de); end
        if (rgb !== 6'd0) begin errors++; $display("FAIL reset_rgb got=%b exp=000000", rgb); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        if (hpos !== 10'd0) begin errors++; $display("FAIL reset_hpos got=%0d exp=0", hpos); end
        if (vpos !== 10'd0) begin errors++; $display("FAIL reset_vpos got=%0d exp=0", vpos); end
        rst_n = 1'b1;
        @(negedge clk);
        checks += 4;
        if (hpos !== 10'd0) begin errors++; $display("FAIL release_hpos got=%0d exp=0", hpos); end
        if (vpos !== 10'd0) begin errors++; $display("FAIL release_vpos got=%0d exp=0", vpos); end
        if (de !== 1'b1) begin errors++; $display("FAIL release_de got=%b exp=1", de); end
        if (rgb !== exp_col(0, 0, SQ)) begin
            errors++; $display("FAIL release_rgb got=%b exp=%b", rgb, exp_col(0, 0, SQ));
        end
    endtask

    task automatic test_sync_timing();
        int seq_bad = 0, map_bad = 0;
        int hs_run = 0, hs_runs = 0, hs_bad_len = 0, hs_last = -1, hs_bad_per = 0;
        int vs_low = 0, vs_falls = 0, vs_last = -1, vs_per = 0;
        int de_run = 0, de_lines = 0, de_bad_len = 0;
        int ft_count = 0, ft_last = -1, ft_per = 0;
        int eh = 0, ev = 0;
        logic prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0;
        logic exp_hs, exp_vs, exp_de, exp_ft;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (hpos !== 10'(eh) || vpos !== 10'(ev)) seq_bad++;
            exp_hs = !(eh >= HA + HF && eh <= HA + HF + HS - 1);
            exp_vs = !(ev >= VA + VF && ev <= VA + VF + VS - 1);
            exp_de = (eh < HA) && (ev < VA);
            exp_ft = (eh == 0) && (ev == VA);
            if (hsync !== exp_hs || vsync !== exp_vs || de !== exp_de || frame_tick !== exp_ft)
                map_bad++;
            if (hsync == 1'b0) hs_run++;
            else if (prev_hs == 1'b0) begin
                if (hs_run != HS) hs_bad_len++;
                hs_runs++;
                hs_run = 0;
            end
            if (prev_hs == 1'b1 && hsync == 1'b0) begin
                if (hs_last >= 0 && c - hs_last != HT) hs_bad_per++;
                hs_last = c;
            end
            if (vsync == 1'b0) vs_low++;
            if (prev_vs == 1'b1 && vsync == 1'b0) begin
                if (vs_last >= 0) vs_per = c - vs_last;
                vs_last = c;
                vs_falls++;
            end
            if (de == 1'b1) de_run++;
            else if (prev_de == 1'b1) begin
                if (de_run != HA) de_bad_len++;
                de_lines++;
                de_run = 0;
            end
            if (frame_tick == 1'b1) begin
                if (ft_last >= 0) ft_per = c - ft_last;
                ft_last = c;
                ft_count++;
            end
            prev_hs = hsync;
            prev_vs = vsync;
            prev_de = de;
            eh = (eh == HT - 1) ? 0 : eh + 1;
            if (eh == 0) ev = (ev == VT - 1) ? 0 : ev + 1;
        end
        checks += 10;
        if (seq_bad != 0) begin errors++; $display("FAIL pos_sequence bad_samples=%0d exp=0", seq_bad); end
        if (map_bad != 0) begin errors++; $display("FAIL sync_map bad_samples=%0d exp=0", map_bad); end
        if (hs_bad_len != 0 || hs_runs != 2 * VT) begin
            errors++; $display("FAIL hsync_width bad=%0d pulses=%0d exp_pulses=%0d", hs_bad_len, hs_runs, 2 * VT);
        end
        if (hs_bad_per != 0) begin errors++; $display("FAIL hsync_period bad=%0d exp=0", hs_bad_per); end
        if (vs_low != 2 * VS * HT) begin errors++; $display("FAIL vsync_low got=%0d exp=%0d", vs_low, 2 * VS * HT); end
        if (vs_falls != 2 || vs_per != FRAME) begin
            errors++; $display("FAIL vsync_period falls=%0d period=%0d exp=%0d", vs_falls, vs_per, FRAME);
        end
        if (de_lines != 2 * VA) begin errors++; $display("FAIL de_lines got=%0d exp=%0d", de_lines, 2 * VA); end
        if (de_bad_len != 0) begin errors++; $display("FAIL de_width bad=%0d exp=0", de_bad_len); end
        if (ft_count != 2) begin errors++; $display("FAIL tick_count got=%0d exp=2", ft_count); end
        if (ft_per != FRAME) begin errors++; $display("FAIL tick_period got=%0d exp=%0d", ft_per, FRAME); end
    endtask

    task automatic test_latch_render();
        int px[5] = '{19, 20, 36, 35, 20};
        int py[5] = '{10, 10, 10, 25, 26};
        logic [5:0] pc[5] = '{BG, SQ, BG, SQ, BG};
        sq_x = 10'd20;
        sq_y = 10'd10;
        sq_valid = 1'b1;
        wait_tick();
        for (int i = 0; i < 5; i++) begin
            wait_pix(px[i], py[i]);
            checks++;
            if (rgb !== exp_col(px[i], py[i], pc[i])) begin
                errors++;
                $display("FAIL latch_render (%0d,%0d) got=%b exp=%b", px[i], py[i], rgb, exp_col(px[i], py[i], pc[i]));
            end
        end
    endtask

    task automatic test_anti_tearing();
        wait_tick();
        wait_pix(0, 5);
        sq_x = 10'd40;
        wait_pix(20, 10);
        checks++;
        if (rgb !== SQ) begin errors++; $display("FAIL tear_old_x got=%b exp=%b", rgb, SQ); end
        wait_pix(40, 10);
        checks++;
        if (rgb !== BG) begin errors++; $display("FAIL tear_new_x_early got=%b exp=%b", rgb, BG); end
        wait_tick();
        wait_pix(20, 10);
        checks++;
        if (rgb !== BG) begin errors++; $display("FAIL tear_old_x_next got=%b exp=%b", rgb, BG); end
        wait_pix(40, 10);
        checks++;
        if (rgb !== SQ) begin errors++; $display("FAIL tear_new_x_next got=%b exp=%b", rgb, SQ); end
    endtask

    task automatic test_clip_hold();
        int px[9] = '{0, 56, 63, 0, 55, 56, 63, 55, 63};
        int py[9] = '{0, 0, 0, 32, 32, 32, 32, 39, 39};
        logic [5:0] pc[9] = '{BG, BG, BG, BG, BG, SQ, SQ, BG, SQ};
        sq_x = 10'(HA - 8);
        sq_y = 10'(VA - 8);
        wait_tick();
        for (int i = 0; i < 9; i++) begin
            wait_pix(px[i], py[i]);
            checks++;
            if (rgb !== exp_col(px[i], py[i], pc[i])) begin
                errors++;
                $display("FAIL clip (%0d,%0d) got=%b exp=%b", px[i], py[i], rgb, exp_col(px[i], py[i], pc[i]));
            end
        end
        sq_valid = 1'b0;
        sq_x = 10'd5;
        sq_y = 10'd5;
        wait_tick();
        wait_pix(5, 5);
        checks++;
        if (rgb !== BG) begin errors++; $display("FAIL hold_new_pos got=%b exp=%b", rgb, BG); end
        wait_pix(56, 32);
        checks++;
        if (rgb !== SQ) begin errors++; $display("FAIL hold_old_pos got=%b exp=%b", rgb, SQ); end
    endtask

    task automatic test_mid_reset();
        int px[4] = '{0, 5, 0, 5};
        int py[4] = '{0, 0, 5, 5};
        wait_pix(30, 20);
        rst_n = 1'b0;
        @(negedge clk);
        checks += 5;
        if (hpos !== 10'd0 || vpos !== 10'd0) begin
            errors++; $display("FAIL midreset_pos got=(%0d,%0d) exp=(0,0)", hpos, vpos);
        end
        if (de !== 1'b0) begin errors++; $display("FAIL midreset_de got=%b exp=0", de); end
        if (rgb !== 6'd0) begin errors++; $display("FAIL midreset_rgb got=%b exp=000000", rgb); end
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++; $display("FAIL midreset_sync got=%b%b exp=11", hsync, vsync);
        end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL midreset_tick got=%b exp=0", frame_tick); end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_pix(px[i], py[i]);
            checks++;
            if (hpos !== 10'(px[i]) || vpos !== 10'(py[i]) || rgb !== exp_col(px[i], py[i], SQ)) begin
                errors++;
                $display("FAIL midreset_square (%0d,%0d) got=%b at (%0d,%0d) exp=%b", px[i], py[i], rgb,
                         hpos, vpos, exp_col(px[i], py[i], SQ));
            end
        end
    endtask

`ifdef VGA_BORDER_EN
    task automatic test_border();
        int px[4] = '{10, 0, 63, 10};
        int py[4] = '{0, 10, 10, 39};
        for (int i = 0; i < 4; i++) begin
            wait_pix(px[i], py[i]);
            checks++;
            if (rgb !== WH) begin
                errors++; $display("FAIL border (%0d,%0d) got=%b exp=%b", px[i], py[i], rgb, WH);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sync_timing();
        test_latch_render();
        test_anti_tearing();
        test_clip_hold();
        test_mid_reset();
`ifdef VGA_BORDER_EN
        test_border();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
